// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV64I sequencer: FETCH/DECODE/EXEC/MEM/WB with an illegal-opcode TRAP.
// All control outputs decode combinationally from the state register, inst and the acks.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic        br_taken,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        ir_we,
    output logic [2:0]  immgen_op,
    output logic        alu_src_a,
    output logic        alu_src_b,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        retire,
    output logic        illegal,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_RW     = 7'b0111011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_IW     = 7'b0011011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    state_t state_q, state_d;

    logic       is_legal, is_load, is_store, is_branch, is_jal, is_jalr, is_lui;
    logic [2:0] imm_type;
    logic       src_a, src_b;

    always_comb begin
        is_legal  = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
        is_lui    = 1'b0;
        imm_type  = 3'b000;
        src_a     = 1'b0;
        src_b     = 1'b0;
        case (inst[6:0])
            OP_R, OP_RW:     is_legal = 1'b1;
            OP_IALU, OP_IW:  begin is_legal = 1'b1; imm_type = 3'b001; src_b = 1'b1; end
            OP_LOAD:         begin is_legal = 1'b1; is_load = 1'b1; imm_type = 3'b001; src_b = 1'b1; end
            OP_STORE:        begin is_legal = 1'b1; is_store = 1'b1; imm_type = 3'b010; src_b = 1'b1; end
            OP_BRANCH:       begin is_legal = 1'b1; is_branch = 1'b1; imm_type = 3'b011; end
            OP_JAL:          begin is_legal = 1'b1; is_jal = 1'b1; imm_type = 3'b101; end
            OP_JALR:         begin is_legal = 1'b1; is_jalr = 1'b1; imm_type = 3'b001; src_b = 1'b1; end
            OP_LUI:          begin is_legal = 1'b1; is_lui = 1'b1; imm_type = 3'b100; end
            OP_AUIPC:        begin is_legal = 1'b1; imm_type = 3'b100; src_a = 1'b1; src_b = 1'b1; end
            default:         is_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= FETCH;
        else     state_q <= state_d;
    end

    // Reset gates every output so an in-flight request or retire never escapes.
    always_comb begin
        state_d   = state_q;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        ir_we     = 1'b0;
        immgen_op = 3'b000;
        alu_src_a = 1'b0;
        alu_src_b = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = 2'b00;
        rf_we     = 1'b0;
        wb_sel    = 2'b00;
        retire    = 1'b0;
        illegal   = 1'b0;
        state     = 3'd0;
        if (!rst) begin
            state = state_q;
            if (state_q != FETCH && state_q != TRAP) begin
                immgen_op = imm_type;
                alu_src_a = src_a;
                alu_src_b = src_b;
            end
            case (state_q)
                FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        ir_we   = 1'b1;
                        state_d = DECODE;
                    end
                end
                DECODE: state_d = is_legal ? EXEC : TRAP;
                EXEC: begin
                    if (is_load || is_store) begin
                        state_d = MEM;
                    end else if (is_branch) begin
                        pc_we   = 1'b1;
                        pc_sel  = br_taken ? 2'b01 : 2'b00;
                        retire  = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end
                MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = is_store;
                    if (dmem_ack) begin
                        if (is_store) begin
                            pc_we   = 1'b1;
                            retire  = 1'b1;
                            state_d = FETCH;
                        end else begin
                            state_d = WB;
                        end
                    end
                end
                WB: begin
                    rf_we   = 1'b1;
                    pc_we   = 1'b1;
                    retire  = 1'b1;
                    wb_sel  = is_load ? 2'b01 : (is_jal || is_jalr) ? 2'b10 : is_lui ? 2'b11 : 2'b00;
                    pc_sel  = is_jal ? 2'b01 : is_jalr ? 2'b10 : 2'b00;
                    state_d = FETCH;
                end
                TRAP:    illegal = 1'b1;
                default: state_d = FETCH;
            endcase
        end
    end

endmodule
